// File: rtl/axis_skid_pipe_pkg.sv
// Helpers shared by the axis_skid_pipe stream pipeline.
package axis_skid_pipe_pkg;

  // Bits needed to count 0..capacity beats, never narrower than one bit.
  function automatic int occ_width(input int capacity);
    int w;
    w = $clog2(capacity + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_skidbuffer.sv
// Single AXI-Stream skid stage: registered ready, optional registered outputs,
// optional zeroing of idle payload registers.
module axis_skidbuffer #(
  parameter int DW           = 17,
  parameter bit OPT_OUTREG   = 1'b1,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          skid_load;

  // Ready comes straight from a flop so the downstream ready path is cut here.
  assign in_ready = !r_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (skid_load) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data <= '0;
    end else if (skid_load) begin
      r_data <= in_data;
    end else if (OPT_LOWPOWER && out_ready) begin
      r_data <= '0;
    end
  end

  if (OPT_OUTREG) begin : g_outreg
    logic          o_valid;
    logic [DW-1:0] o_data;

    assign skid_load = in_valid && in_ready && o_valid && !out_ready;

    // The skid beat always takes priority so older data leaves first.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        o_valid <= 1'b0;
        o_data  <= '0;
      end else if (!o_valid || out_ready) begin
        o_valid <= r_valid || in_valid;
        if (r_valid) begin
          o_data <= r_data;
        end else if (!OPT_LOWPOWER || in_valid) begin
          o_data <= in_data;
        end else begin
          o_data <= '0;
        end
      end
    end

    assign out_valid = o_valid;
    assign out_data  = o_data;
  end else begin : g_comb
    assign skid_load = in_valid && in_ready && !out_ready;
    assign out_valid = r_valid || in_valid;

    always_comb begin
      out_data = in_data;
      if (r_valid) begin
        out_data = r_data;
      end else if (OPT_LOWPOWER && !in_valid) begin
        out_data = '0;
      end
    end
  end

endmodule

// File: rtl/axis_skid_pipe.sv
// AXI-Stream register pipeline built from NSTAGES chained skid stages,
// with a count of the beats currently held inside.
module axis_skid_pipe
  import axis_skid_pipe_pkg::*;
#(
  parameter int DW           = 16,
  parameter int NSTAGES      = 2,
  parameter bit OPT_OUTREG   = 1'b1,
  parameter bit OPT_LOWPOWER = 1'b0,
  localparam int CAPACITY    = NSTAGES * (OPT_OUTREG ? 2 : 1),
  localparam int LGOCC       = occ_width(CAPACITY)
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [DW-1:0]    S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [DW-1:0]    M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic [LGOCC-1:0] o_occupancy
);

  logic             s_hs;
  logic             m_hs;
  logic [LGOCC-1:0] occupancy;

  if (NSTAGES == 0) begin : g_wire
    assign M_AXIS_TVALID = S_AXIS_TVALID;
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TLAST  = S_AXIS_TLAST;
    assign S_AXIS_TREADY = M_AXIS_TREADY;
  end else begin : g_pipe
    // Each stage keeps its own link signals so the chain has no shared vectors.
    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
      logic        in_valid;
      logic        in_ready;
      logic [DW:0] in_data;
      logic        out_valid;
      logic        out_ready;
      logic [DW:0] out_data;

      if (i == 0) begin : g_head
        assign in_valid = S_AXIS_TVALID && S_AXI_ARESETN;
        assign in_data  = {S_AXIS_TLAST, S_AXIS_TDATA};
      end else begin : g_link
        assign in_valid = g_stage[i-1].out_valid;
        assign in_data  = g_stage[i-1].out_data;
      end

      if (i == NSTAGES - 1) begin : g_tail
        assign out_ready = M_AXIS_TREADY;
      end else begin : g_next
        assign out_ready = g_stage[i+1].in_ready;
      end

      axis_skidbuffer #(
        .DW           (DW + 1),
        .OPT_OUTREG   (OPT_OUTREG),
        .OPT_LOWPOWER (OPT_LOWPOWER)
      ) u_stage (
        .clk       (S_AXI_ACLK),
        .resetn    (S_AXI_ARESETN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
      );
    end

    assign S_AXIS_TREADY = g_stage[0].in_ready && S_AXI_ARESETN;
    assign M_AXIS_TVALID = g_stage[NSTAGES-1].out_valid;
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = g_stage[NSTAGES-1].out_data;
  end

  assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;

  // In passthrough both handshakes coincide, so the count stays at zero.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      occupancy <= '0;
    end else if (s_hs && !m_hs) begin
      occupancy <= occupancy + LGOCC'(1);
    end else if (!s_hs && m_hs) begin
      occupancy <= occupancy - LGOCC'(1);
    end
  end

  assign o_occupancy = occupancy;

endmodule
